// File: rtl/spi_byte_engine.sv
// Byte-wide SPI mode-0 master: one full-duplex 8-bit exchange per accepted wr, dsr pulse on completion.
// Optional build macro SPI_MISO_SYNC_EN adds a two-flop miso synchronizer and late (pre-fall) sampling.
module spi_byte_engine #(
  parameter int SLOW_HALF = 32,
  parameter int FAST_HALF = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       fast,
  input  logic       cs,
  output logic [7:0] dout,
  output logic       dsr,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  // Terminal divider count (half-period minus one), clamped to what the 8-bit divider can hold.
  function automatic logic [7:0] half_m1_f(input int h);
    int heff;
    heff = (h < 1) ? 1 : ((h > 255) ? 255 : h);
`ifdef SPI_MISO_SYNC_EN
    if (heff < 2) heff = 2;
`endif
    return 8'(heff - 1);
  endfunction

  localparam logic [7:0] SLOW_M1 = half_m1_f(SLOW_HALF);
  localparam logic [7:0] FAST_M1 = half_m1_f(FAST_HALF);

  state_t     state_q;
  logic [7:0] div_q, div_d;
  logic [7:0] sr_q;
  logic [2:0] bit_q;
  logic       fast_q;
  logic [7:0] half_m1;
  logic       edge_hit;
  logic       miso_s;

  always_comb begin
    half_m1  = fast_q ? FAST_M1 : SLOW_M1;
    edge_hit = (div_q == half_m1);
    div_d    = edge_hit ? 8'd0 : div_q + 8'd1;
  end

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], miso};
  end

  assign miso_s = sync_q[1];
`else
  assign miso_s = miso;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= 3'd0;
      sr_q    <= 8'd0;
      fast_q  <= 1'b0;
      dout    <= 8'hFF;
      dsr     <= 1'b0;
      busy    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b1;
      cs_n    <= 1'b1;
    end else if (ce) begin
      // Chip select only follows the request between bytes.
      if (!busy) cs_n <= ~cs;

      case (state_q)
        IDLE: begin
          dsr <= 1'b0;
          if (wr) begin
            sr_q    <= din;
            fast_q  <= fast;
            mosi    <= din[7];
            busy    <= 1'b1;
            div_q   <= 8'd0;
            bit_q   <= 3'd0;
            state_q <= LOW;
          end
        end

        LOW: begin
          div_q <= div_d;
          if (edge_hit) begin
            sclk    <= 1'b1;
            state_q <= HIGH;
`ifndef SPI_MISO_SYNC_EN
            sr_q    <= {sr_q[6:0], miso_s};
`endif
          end
        end

        HIGH: begin
          div_q <= div_d;
          if (edge_hit) begin
            sclk <= 1'b0;
`ifdef SPI_MISO_SYNC_EN
            // Sample just before the fall so the synchronizer has settled.
            sr_q <= {sr_q[6:0], miso_s};
`endif
            if (bit_q == 3'd7) begin
              state_q <= DONE;
            end else begin
              bit_q   <= bit_q + 3'd1;
`ifdef SPI_MISO_SYNC_EN
              mosi    <= sr_q[6];
`else
              mosi    <= sr_q[7];
`endif
              state_q <= LOW;
            end
          end
        end

        DONE: begin
          dout    <= sr_q;
          dsr     <= 1'b1;
          busy    <= 1'b0;
          mosi    <= 1'b1;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Scoreboard bench for spi_byte_engine: stimulus pushes expected bytes/latencies, a negedge monitor checks each dsr.
module tb_spi_byte_engine;
  localparam int SLOW = 32;
  localparam int FAST = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       ce = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       fast = 1'b1;
  logic       cs = 1'b0;
  logic       miso_val = 1'b1;
  logic       loop_en = 1'b0;
  logic [7:0] dout;
  logic       dsr, busy, sclk, mosi, cs_n;
  logic       miso;

  assign miso = loop_en ? mosi : miso_val;

  spi_byte_engine #(.SLOW_HALF(SLOW), .FAST_HALF(FAST)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .wr(wr), .din(din), .fast(fast), .cs(cs),
    .dout(dout), .dsr(dsr), .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ticks = 0;
  int   accept_tick = 0;
  bit   gate = 1'b0;

  function automatic int heff(input int h);
`ifdef SPI_MISO_SYNC_EN
    if (h < 2) return 2;
`endif
    return h;
  endfunction

  function automatic int lat(input bit f);
    return 16 * heff(f ? FAST : SLOW) + 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock; counts ce ticks and optionally toggles ce for the gating test.
  task automatic step(output bit was_ce);
    @(posedge clk);
    was_ce = ce;
    if (ce) ticks++;
    #1;
    ce = gate ? ~ce : 1'b1;
  endtask

  task automatic steps(input int n);
    bit w;
    repeat (n) step(w);
  endtask

  task automatic start(input logic [7:0] d, input bit f, input logic [7:0] e);
    bit w;
    int guard;
    guard = 0;
    wr = 1'b1;
    din = d;
    fast = f;
    do begin
      step(w);
      guard++;
    end while (!w && guard < 10);
    wr = 1'b0;
    accept_tick = ticks;
    sb.push_back('{e, lat(f)});
  endtask

  task automatic wait_idle(input int budget);
    bit w;
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step(w);
      n++;
    end
    if (sb.size() != 0) begin
      check("dsr_timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor state
  logic dsr_prev = 1'b0, sclk_prev = 1'b0, busy_prev = 1'b0;
  int   rises = 0, dsr_w = 0, last_dsr_w = 0, last_hi = 0, last_lo = 0, sclk_chg = 0;
  bit   mosi1 = 1'b0;

  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      rises = 0;
      mosi1 = 1'b0;
    end
    if (busy && mosi) mosi1 = 1'b1;
    if (sclk != sclk_prev) begin
      if (sclk) begin
        rises++;
        last_lo = ticks - sclk_chg;
      end else begin
        last_hi = ticks - sclk_chg;
      end
      sclk_chg = ticks;
    end
    if (dsr && !dsr_prev) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_dsr: got dsr=%0b with dout=%0h, expected no pulse", dsr, dout);
      end else begin
        mon_e = sb.pop_front();
        check("dout", {24'd0, dout}, {24'd0, mon_e.d});
        check("latency", ticks - accept_tick, mon_e.lat);
        check("busy_on_dsr", {31'd0, busy}, 32'd0);
        check("sclk_rises", rises, 8);
      end
      dsr_w = 0;
    end
    if (dsr) dsr_w++;
    else if (dsr_prev) last_dsr_w = dsr_w;
    dsr_prev  = dsr;
    sclk_prev = sclk;
    busy_prev = busy;
  end

  initial begin
    bit w;
    int a1, n;

    #2 reset_n = 1'b0;
    steps(3);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd1);
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_dout", {24'd0, dout}, 32'hFF);
    check("rst_dsr",  {31'd0, dsr},  32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    reset_n = 1'b1;
    cs = 1'b1;
    steps(2);
    check("cs_n_before_start", {31'd0, cs_n}, 32'd0);

    // Loopback, fast
    loop_en = 1'b1;
    start(8'hA5, 1'b1, 8'hA5);
    wait_idle(200);
    steps(2);
    check("dsr_width_fast", last_dsr_w, 1);

    // Slow speed, miso high, transmit zeros
    loop_en = 1'b0;
    miso_val = 1'b1;
    start(8'h00, 1'b0, 8'hFF);
    wait_idle(2000);
    steps(2);
    check("mosi_low_during_byte", {31'd0, mosi1}, 32'd0);
    check("slow_high_phase", last_hi, heff(SLOW));
    check("slow_low_phase", last_lo, heff(SLOW));

    // Write during busy is ignored
    loop_en = 1'b1;
    start(8'hC3, 1'b1, 8'hC3);
    steps(4);
    wr = 1'b1;
    din = 8'h00;
    fast = 1'b0;
    step(w);
    wr = 1'b0;
    fast = 1'b1;
    wait_idle(200);
    steps(3);

    // Back-to-back: wr on the tick right after dsr
    start(8'h96, 1'b1, 8'h96);
    a1 = accept_tick;
    n = 0;
    do begin
      step(w);
      n++;
    end while (!dsr && n < 200);
    check("dsr_seen_b2b", {31'd0, dsr}, 32'd1);
    start(8'h69, 1'b1, 8'h69);
    check("b2b_spacing", accept_tick - a1, 16 * heff(FAST) + 2);
    wait_idle(200);
    steps(3);

    // ce gating 1-0-1-0
    gate = 1'b1;
    start(8'h3C, 1'b1, 8'h3C);
    wait_idle(400);
    steps(3);
    gate = 1'b0;
    ce = 1'b1;
    check("dsr_width_gated", last_dsr_w, 2);
    steps(2);

    // Reset mid-transfer after the 4th sclk rise
    start(8'hF0, 1'b1, 8'hF0);
    n = 0;
    do begin
      step(w);
      n++;
    end while (rises < 4 && n < 200);
    reset_n = 1'b0;
    #1;
    check("abort_sclk", {31'd0, sclk}, 32'd0);
    check("abort_mosi", {31'd0, mosi}, 32'd1);
    check("abort_cs_n", {31'd0, cs_n}, 32'd1);
    check("abort_dout", {24'd0, dout}, 32'hFF);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_dsr",  {31'd0, dsr},  32'd0);
    sb.delete();
    steps(2);
    reset_n = 1'b1;
    steps(60);
    check("post_abort_dout", {24'd0, dout}, 32'hFF);
    check("post_abort_busy", {31'd0, busy}, 32'd0);

    // Loopback 5A (effective half-period depends on the miso sync build)
    start(8'h5A, 1'b1, 8'h5A);
    wait_idle(400);
    steps(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
